// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Purpose:
//   Shares a single carry_select_adder between two requesters. Each requester
//   offers an operand pair over a valid/ready handshake. A round-robin arbiter
//   picks one requester per cycle. The sum, carry-out and requester id land in
//   a single-entry output register that has its own valid/ready handshake.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_valid/a/b/ready     requester 0 operand handshake
//   req1_valid/a/b/ready     requester 1 operand handshake
//   res_valid/ready          result register handshake
//   res_sum, res_carry       registered sum and carry-out
//   res_id                   requester that produced the current result
//   cnt0, cnt1               saturating counts of accepted requests
//
// Also contains carry_select_adder, the shared WIDTH-bit adder core.
// ---------------------------------------------------------------------------

// Carry-select adder. Each block precomputes its sum for carry-in 0 and
// carry-in 1. The incoming block carry then selects between the two.
module carry_select_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // The largest block size that divides WIDTH evenly, so no block is partial
    localparam int BLK = (WIDTH % 8 == 0) ? 8 : ((WIDTH % 4 == 0) ? 4 : 1);
    localparam int NB  = WIDTH / BLK;

    logic [NB:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;
        assign s0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
        assign s1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + (BLK+1)'(1);
        assign sum[i*BLK +: BLK] = carry[i] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign carry[i+1]        = carry[i] ? s1[BLK]     : s0[BLK];
    end

    assign cout = carry[NB];
endmodule

module adder_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    out_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             accept0;
    logic             accept1;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    // When both requesters are valid, the one not served last wins. Because
    // last resets to 1, requester 0 wins the first tie. A full register can
    // still accept a new result if the consumer drains it this cycle.
    always_comb begin
        can_accept = (state_q == EMPTY) || res_ready;
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && (!req0_valid || !last_q);
        req0_ready = !rst && can_accept && grant0;
        req1_ready = !rst && can_accept && grant1;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
        add_a      = accept1 ? req1_a : req0_a;
        add_b      = accept1 ? req1_b : req0_b;
    end

    carry_select_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_carry)
    );

    // Next-state logic for the output register. An accept always refills the
    // register, even if it drains in the same cycle. A drain with no accept
    // only clears valid, so the data outputs keep their old values.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (accept0 || accept1) begin
            state_d = FULL;
            sum_d   = add_sum;
            carry_d = add_carry;
            id_d    = accept1;
            last_d  = accept1;
            if (accept0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
            if (accept1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            last_q  <= 1'b1;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_carry = carry_q;
    assign res_id    = id_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Directed self-checking bench for adder_share_arbiter, built with CNT_W=4 so
// that counter saturation can be reached quickly. An accept pushes its
// expected result into a scoreboard. The entry is popped and compared when
// the result appears on the output register.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_id;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             id;
    } result_t;

    result_t          sb[$];
    result_t          last_res;
    logic             exp_valid;
    logic [CNT_W-1:0] exp_cnt0;
    logic [CNT_W-1:0] exp_cnt1;
    int               n_assert = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compares every output-register field against the bench's expectation.
    task automatic checkResult(input string tag);
        checkOutput({tag, " res_valid"}, res_valid, exp_valid);
        checkOutput({tag, " res_sum"}, res_sum, last_res.sum);
        checkOutput({tag, " res_carry"}, res_carry, last_res.carry);
        checkOutput({tag, " res_id"}, res_id, last_res.id);
        checkOutput({tag, " cnt0"}, cnt0, exp_cnt0);
        checkOutput({tag, " cnt1"}, cnt1, exp_cnt1);
    endtask

    // This task is called just after a negative clock edge. It drives one
    // cycle of stimulus and checks the combinational readies. It pushes the
    // expected result if a grant is expected (0/1; 2 means no grant). After
    // the next clock edge it checks the output register.
    task automatic applyStimulus(input string tag, input logic v0, input logic [WIDTH-1:0] a0,
                                 input logic [WIDTH-1:0] b0, input logic v1,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic rr, input int exp_grant);
        logic [WIDTH:0] full_sum;
        result_t        front;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        res_ready  = rr;
        #1;
        checkOutput({tag, " req0_ready"}, req0_ready, (exp_grant == 0));
        checkOutput({tag, " req1_ready"}, req1_ready, (exp_grant == 1));
        if (exp_grant == 0) begin
            full_sum = {1'b0, a0} + {1'b0, b0};
            sb.push_back({full_sum[WIDTH-1:0], full_sum[WIDTH], 1'b0});
            if (exp_cnt0 != {CNT_W{1'b1}}) exp_cnt0 = exp_cnt0 + 1'b1;
        end else if (exp_grant == 1) begin
            full_sum = {1'b0, a1} + {1'b0, b1};
            sb.push_back({full_sum[WIDTH-1:0], full_sum[WIDTH], 1'b1});
            if (exp_cnt1 != {CNT_W{1'b1}}) exp_cnt1 = exp_cnt1 + 1'b1;
        end
        @(negedge clk);
        if (exp_grant < 2) begin
            front     = sb.pop_front();
            last_res  = front;
            exp_valid = 1'b1;
        end else if (exp_valid && rr) begin
            exp_valid = 1'b0;
        end
        checkResult(tag);
    endtask

    // Applies reset while both requesters hold valid and the consumer stalls.
    // The readies must stay low, and after the edge every output is back at
    // its reset value.
    task automatic doReset(input string tag);
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 32'h1111_1111;
        req0_b     = 32'h2222_2222;
        req1_valid = 1'b1;
        req1_a     = 32'h3333_3333;
        req1_b     = 32'h4444_4444;
        res_ready  = 1'b0;
        #1;
        checkOutput({tag, " req0_ready in reset"}, req0_ready, 1'b0);
        checkOutput({tag, " req1_ready in reset"}, req1_ready, 1'b0);
        @(negedge clk);
        sb.delete();
        last_res  = '0;
        exp_valid = 1'b0;
        exp_cnt0  = '0;
        exp_cnt1  = '0;
        checkResult(tag);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        res_ready  = 1'b0;
        @(negedge clk);
        doReset("reset0");

        // Single requester 0, then single requester 1, then a drain with no accept
        applyStimulus("req0 only", 1'b1, 32'h8ED5_6AC8, 32'h7DA6_62A9, 1'b0, '0, '0, 1'b1, 0);
        checkOutput("req0 sum const", res_sum, 32'h0C7B_CD71);
        checkOutput("req0 carry const", res_carry, 1'b1);
        applyStimulus("req1 only", 1'b0, '0, '0, 1'b1, 32'h2EEA_AAC8, 32'h56A6_7559, 1'b1, 1);
        checkOutput("req1 sum const", res_sum, 32'h8591_2021);
        applyStimulus("drain", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2);

        // Both requesters valid from reset: grants alternate 0,1,0,1
        doReset("reset1");
        for (int i = 0; i < 4; i++) begin
            applyStimulus("rr both", 1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom,
                          1'b1, i % 2);
        end
        checkOutput("rr cnt0", cnt0, 4'd2);
        checkOutput("rr cnt1", cnt1, 4'd2);

        // Backpressure for 3 cycles, then a release that accepts requester 0
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000,
                          32'h8000_0000, 1'b0, 2);
        end
        applyStimulus("release", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000,
                      32'h8000_0000, 1'b1, 0);

        // Reset while FULL and stalled, then requester 0 wins the next tie
        doReset("reset full");
        applyStimulus("tie after reset", 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1,
                      32'h0000_0009, 32'h0000_000B, 1'b1, 0);
        applyStimulus("drain2", 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2);

        // 17 back-to-back requester 0 accepts saturate the 4-bit counter
        doReset("reset sat");
        for (int i = 0; i < 17; i++) begin
            applyStimulus("sat", 1'b1, $urandom, $urandom, 1'b0, '0, '0, 1'b1, 0);
        end
        checkOutput("sat cnt0", cnt0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
